rename_map_table: RTL and testbench

//  3-wide register-rename map table (RAT) for the R10K pipeline; sits in dispatch, directly upstream of Freelist.

---
 rtl/rename_map_table_pkg.sv | 36 +++
 rtl/rename_map_table_src_lookup.sv | 51 +++++
 rtl/rename_map_table.sv | 148 ++++++++++++++
 tb/tb_rename_map_table.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_map_table_pkg.sv
// rtl/rename_map_table_pkg.sv - shared sizes, types and helpers for the rename map table
package rename_map_table_pkg;

  localparam int WIDTH     = 3;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int CDB_WIDTH = 3;
  localparam int PRW       = $clog2(PHYS_REGS);
  localparam int AREGW     = $clog2(ARCH_REGS);

  typedef logic [PRW-1:0]   preg_t;
  typedef logic [AREGW-1:0] areg_t;

  // One dispatch slot as seen by the renamer
  typedef struct packed {
    logic  valid;
    areg_t dest;
    areg_t src1;
    areg_t src2;
  } rn_slot_t;

  // True when any valid completion broadcast carries the given PR
  function automatic logic cdb_hit(
    input logic [PRW-1:0]                 preg,
    input logic [CDB_WIDTH-1:0]           valid,
    input logic [CDB_WIDTH-1:0][PRW-1:0]  tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (valid[k] && (tag[k] == preg)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rename_map_table_src_lookup.sv
// rtl/rename_map_table_src_lookup.sv - per-operand map read with intra-group and CDB bypass
module rename_src_lookup
  import rename_map_table_pkg::*;
#(
  parameter int SLOT = 0
) (
  input  logic [AREGW-1:0]                  i_areg,
  input  logic [ARCH_REGS-1:0][PRW-1:0]     i_map,
  input  logic [PHYS_REGS-1:0]              i_ready,
  input  logic [WIDTH-1:0]                  i_grp_wr,
  input  logic [WIDTH-1:0][AREGW-1:0]       i_grp_dest,
  input  logic [WIDTH-1:0][PRW-1:0]         i_grp_preg,
  input  logic [CDB_WIDTH-1:0]              i_cdb_valid,
  input  logic [CDB_WIDTH-1:0][PRW-1:0]     i_cdb_tag,
  output logic [PRW-1:0]                    o_preg,
  output logic                              o_ready
);

  logic             w_byp_hit;
  logic [PRW-1:0]   w_byp_preg;
  logic [PRW-1:0]   w_map_preg;

  assign w_map_preg = i_map[i_areg];

  // Youngest older slot in the group writing this areg supplies the mapping
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_preg = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if ((j < SLOT) && i_grp_wr[j] && (i_grp_dest[j] == i_areg)) begin
        w_byp_hit  = 1'b1;
        w_byp_preg = i_grp_preg[j];
      end
    end
  end

  // Zero reg is constant; a bypassed value is still in flight; else map plus CDB forwarding
  always_comb begin
    if (i_areg == '0) begin
      o_preg  = '0;
      o_ready = 1'b1;
    end else if (w_byp_hit) begin
      o_preg  = w_byp_preg;
      o_ready = 1'b0;
    end else begin
      o_preg  = w_map_preg;
      o_ready = i_ready[w_map_preg] | cdb_hit(w_map_preg, i_cdb_valid, i_cdb_tag);
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - 3-wide register rename map table with ready bits and recovery
module rename_map_table
  import rename_map_table_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  rn_valid_mask,
  input  logic [WIDTH-1:0][AREGW-1:0]       rn_dest_areg,
  input  logic [WIDTH-1:0][AREGW-1:0]       rn_src1_areg,
  input  logic [WIDTH-1:0][AREGW-1:0]       rn_src2_areg,
  input  logic [WIDTH-1:0][PRW-1:0]         fl_allocated_pr_list,
  input  logic [WIDTH-1:0]                  fl_alloc_valid_mask,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH-1:0][PRW-1:0]     cdb_tag,
  input  logic                              fch_rec_enable,
  input  logic [ARCH_REGS-1:0][PRW-1:0]     arch_map_in,
  output logic [WIDTH-1:0]                  fl_dispatch_en_mask,
  output logic [WIDTH-1:0]                  rn_accept_mask,
  output logic [WIDTH-1:0][PRW-1:0]         rn_dest_preg,
  output logic [WIDTH-1:0][PRW-1:0]         rn_told_preg,
  output logic [WIDTH-1:0][PRW-1:0]         rn_src1_preg,
  output logic [WIDTH-1:0]                  rn_src1_ready,
  output logic [WIDTH-1:0][PRW-1:0]         rn_src2_preg,
  output logic [WIDTH-1:0]                  rn_src2_ready
);

  logic [ARCH_REGS-1:0][PRW-1:0]  r_map;
  logic [PHYS_REGS-1:0]           r_ready;

  rn_slot_t                       w_slot [WIDTH];
  logic [WIDTH-1:0]               w_need;
  logic [WIDTH-1:0]               w_accept;
  logic [WIDTH-1:0]               w_grp_wr;
  logic                           w_blocked_seen;
  logic [WIDTH-1:0][AREGW-1:0]    w_grp_dest;
  logic [WIDTH-1:0][PRW-1:0]      w_grp_preg;
  logic [WIDTH-1:0][PRW-1:0]      w_src1_preg;
  logic [WIDTH-1:0][PRW-1:0]      w_src2_preg;
  logic [WIDTH-1:0][PRW-1:0]      w_told_preg;
  logic [WIDTH-1:0]               w_src1_ready;
  logic [WIDTH-1:0]               w_src2_ready;
  logic [WIDTH-1:0]               w_told_ready_unused;

  // Gather the per-slot request fields
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_slot[i].valid = rn_valid_mask[i];
      w_slot[i].dest  = rn_dest_areg[i];
      w_slot[i].src1  = rn_src1_areg[i];
      w_slot[i].src2  = rn_src2_areg[i];
    end
  end

  // In-order acceptance: stop at the first slot that needs a PR but has no offer
  always_comb begin
    w_blocked_seen = 1'b0;
    w_need         = '0;
    w_accept       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_need[i] = w_slot[i].valid && (w_slot[i].dest != '0);
      if (w_need[i] && !fl_alloc_valid_mask[i]) w_blocked_seen = 1'b1;
      w_accept[i] = w_slot[i].valid && !w_blocked_seen && !fch_rec_enable;
    end
  end

  // Slots that consume a freelist offer and write a new mapping
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_grp_wr[i]   = w_accept[i] && w_need[i];
      w_grp_dest[i] = w_slot[i].dest;
      w_grp_preg[i] = w_grp_wr[i] ? fl_allocated_pr_list[i] : '0;
    end
  end

  assign fl_dispatch_en_mask = w_grp_wr;
  assign rn_accept_mask      = w_accept;
  assign rn_dest_preg        = w_grp_preg;

  for (genvar g = 0; g < WIDTH; g++) begin : g_slot
    rename_src_lookup #(.SLOT(g)) u_src1 (
      .i_areg      (rn_src1_areg[g]),
      .i_map       (r_map),
      .i_ready     (r_ready),
      .i_grp_wr    (w_grp_wr),
      .i_grp_dest  (w_grp_dest),
      .i_grp_preg  (w_grp_preg),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .o_preg      (w_src1_preg[g]),
      .o_ready     (w_src1_ready[g])
    );

    rename_src_lookup #(.SLOT(g)) u_src2 (
      .i_areg      (rn_src2_areg[g]),
      .i_map       (r_map),
      .i_ready     (r_ready),
      .i_grp_wr    (w_grp_wr),
      .i_grp_dest  (w_grp_dest),
      .i_grp_preg  (w_grp_preg),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .o_preg      (w_src2_preg[g]),
      .o_ready     (w_src2_ready[g])
    );

    // Told is the mapping the destination had just before this slot
    rename_src_lookup #(.SLOT(g)) u_told (
      .i_areg      (rn_dest_areg[g]),
      .i_map       (r_map),
      .i_ready     (r_ready),
      .i_grp_wr    (w_grp_wr),
      .i_grp_dest  (w_grp_dest),
      .i_grp_preg  (w_grp_preg),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .o_preg      (w_told_preg[g]),
      .o_ready     (w_told_ready_unused[g])
    );

    assign rn_src1_preg[g]  = rn_valid_mask[g] ? w_src1_preg[g] : '0;
    assign rn_src1_ready[g] = rn_valid_mask[g] & w_src1_ready[g];
    assign rn_src2_preg[g]  = rn_valid_mask[g] ? w_src2_preg[g] : '0;
    assign rn_src2_ready[g] = rn_valid_mask[g] & w_src2_ready[g];
    assign rn_told_preg[g]  = w_need[g] ? w_told_preg[g] : '0;
  end

  // Map and ready storage: recovery beats dispatch and CDB; allocation clear beats CDB set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < ARCH_REGS; a++) r_map[a] <= PRW'(a);
      r_ready <= '1;
    end else if (fch_rec_enable) begin
      r_map   <= arch_map_in;
      r_ready <= '1;
    end else begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (cdb_valid[k]) r_ready[cdb_tag[k]] <= 1'b1;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (w_grp_wr[i]) begin
          r_map[rn_dest_areg[i]]          <= fl_allocated_pr_list[i];
          r_ready[fl_allocated_pr_list[i]] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// tb/tb_rename_map_table.sv - self-checking bench for rename_map_table
module tb_rename_map_table;
  import rename_map_table_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WIDTH-1:0]                  rn_valid_mask;
  logic [WIDTH-1:0][AREGW-1:0]       rn_dest_areg, rn_src1_areg, rn_src2_areg;
  logic [WIDTH-1:0][PRW-1:0]         fl_allocated_pr_list;
  logic [WIDTH-1:0]                  fl_alloc_valid_mask;
  logic [CDB_WIDTH-1:0]              cdb_valid;
  logic [CDB_WIDTH-1:0][PRW-1:0]     cdb_tag;
  logic                              fch_rec_enable;
  logic [ARCH_REGS-1:0][PRW-1:0]     arch_map_in;
  logic [WIDTH-1:0]                  fl_dispatch_en_mask, rn_accept_mask;
  logic [WIDTH-1:0][PRW-1:0]         rn_dest_preg, rn_told_preg, rn_src1_preg, rn_src2_preg;
  logic [WIDTH-1:0]                  rn_src1_ready, rn_src2_ready;

  rename_map_table dut (
    .clk(clk), .rst(rst),
    .rn_valid_mask(rn_valid_mask), .rn_dest_areg(rn_dest_areg),
    .rn_src1_areg(rn_src1_areg), .rn_src2_areg(rn_src2_areg),
    .fl_allocated_pr_list(fl_allocated_pr_list), .fl_alloc_valid_mask(fl_alloc_valid_mask),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fch_rec_enable(fch_rec_enable),
    .arch_map_in(arch_map_in), .fl_dispatch_en_mask(fl_dispatch_en_mask),
    .rn_accept_mask(rn_accept_mask), .rn_dest_preg(rn_dest_preg), .rn_told_preg(rn_told_preg),
    .rn_src1_preg(rn_src1_preg), .rn_src1_ready(rn_src1_ready),
    .rn_src2_preg(rn_src2_preg), .rn_src2_ready(rn_src2_ready)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_map   [ARCH_REGS];
  bit m_ready [PHYS_REGS];

  // Expected outputs for the current inputs
  bit e_acc [WIDTH], e_disp [WIDTH], e_r1 [WIDTH], e_r2 [WIDTH];
  int e_dest [WIDTH], e_told [WIDTH], e_s1 [WIDTH], e_s2 [WIDTH];

  task automatic idle();
    rn_valid_mask = '0; rn_dest_areg = '0; rn_src1_areg = '0; rn_src2_areg = '0;
    fl_allocated_pr_list = '0; fl_alloc_valid_mask = '0;
    cdb_valid = '0; cdb_tag = '0; fch_rec_enable = 1'b0;
    for (int a = 0; a < ARCH_REGS; a++) arch_map_in[a] = 6'(a);
  endtask

  task automatic model_reset();
    for (int a = 0; a < ARCH_REGS; a++) m_map[a] = a;
    for (int p = 0; p < PHYS_REGS; p++) m_ready[p] = 1'b1;
  endtask

  task automatic model_lookup(input int slot, input int areg, output int p, output bit r);
    bit found;
    found = 0;
    p = 0; r = 1'b1;
    if (areg != 0) begin
      for (int j = slot - 1; j >= 0 && !found; j--) begin
        if (e_disp[j] && int'(rn_dest_areg[j]) == areg) begin
          found = 1; p = e_dest[j]; r = 1'b0;
        end
      end
      if (!found) begin
        p = m_map[areg];
        r = m_ready[p];
        for (int k = 0; k < CDB_WIDTH; k++)
          if (cdb_valid[k] && int'(cdb_tag[k]) == p) r = 1'b1;
      end
    end
  endtask

  task automatic model_eval();
    bit stop, need;
    bit rd;
    int pp;
    stop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      need = rn_valid_mask[i] && rn_dest_areg[i] != 0;
      if (need && !fl_alloc_valid_mask[i]) stop = 1;
      e_acc[i]  = rn_valid_mask[i] && !stop && !fch_rec_enable;
      e_disp[i] = e_acc[i] && need;
      e_dest[i] = e_disp[i] ? int'(fl_allocated_pr_list[i]) : 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      e_s1[i] = 0; e_r1[i] = 0; e_s2[i] = 0; e_r2[i] = 0; e_told[i] = 0;
      if (rn_valid_mask[i]) begin
        model_lookup(i, int'(rn_src1_areg[i]), e_s1[i], e_r1[i]);
        model_lookup(i, int'(rn_src2_areg[i]), e_s2[i], e_r2[i]);
        if (rn_dest_areg[i] != 0) begin
          model_lookup(i, int'(rn_dest_areg[i]), pp, rd);
          e_told[i] = pp;
        end
      end
    end
  endtask

  task automatic model_commit();
    if (fch_rec_enable) begin
      for (int a = 0; a < ARCH_REGS; a++) m_map[a] = int'(arch_map_in[a]);
      for (int p = 0; p < PHYS_REGS; p++) m_ready[p] = 1'b1;
    end else begin
      for (int k = 0; k < CDB_WIDTH; k++) if (cdb_valid[k]) m_ready[cdb_tag[k]] = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        if (e_disp[i]) begin
          m_map[rn_dest_areg[i]] = e_dest[i];
          m_ready[e_dest[i]] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({rn_accept_mask, fl_dispatch_en_mask, rn_src1_ready, rn_src2_ready} !== 12'b0 ||
        rn_src1_preg !== '0 || rn_told_preg !== '0 || rn_dest_preg !== '0) begin
      fails++; $display("FAIL reset_idle_outputs: acc=%b disp=%b s1=%h told=%h", rn_accept_mask, fl_dispatch_en_mask, rn_src1_preg, rn_told_preg);
    end
    rn_valid_mask = 3'b111;
    rn_src1_areg[0] = 5'd1; rn_src1_areg[1] = 5'd2; rn_src1_areg[2] = 5'd3;
    #1;
    tests++;
    if (rn_src1_preg !== {6'd3, 6'd2, 6'd1}) begin
      fails++; $display("FAIL reset_identity_map: got %h want %h", rn_src1_preg, {6'd3, 6'd2, 6'd1});
    end
    tests++;
    if (rn_src1_ready !== 3'b111 || rn_accept_mask !== 3'b111 || fl_dispatch_en_mask !== 3'b000) begin
      fails++; $display("FAIL reset_ready_accept: rdy=%b acc=%b disp=%b want 111 111 000", rn_src1_ready, rn_accept_mask, fl_dispatch_en_mask);
    end
  endtask

  task automatic test_basic_rename();
    @(negedge clk); idle();
    rn_valid_mask = 3'b111; fl_alloc_valid_mask = 3'b111;
    rn_dest_areg[0] = 5'd5; rn_dest_areg[1] = 5'd6; rn_dest_areg[2] = 5'd7;
    fl_allocated_pr_list[0] = 6'd32; fl_allocated_pr_list[1] = 6'd33; fl_allocated_pr_list[2] = 6'd34;
    #1;
    tests++;
    if (rn_accept_mask !== 3'b111 || fl_dispatch_en_mask !== 3'b111) begin
      fails++; $display("FAIL basic_accept: acc=%b disp=%b want 111 111", rn_accept_mask, fl_dispatch_en_mask);
    end
    tests++;
    if (rn_told_preg !== {6'd7, 6'd6, 6'd5} || rn_dest_preg !== {6'd34, 6'd33, 6'd32}) begin
      fails++; $display("FAIL basic_told_dest: told=%h dest=%h", rn_told_preg, rn_dest_preg);
    end
    @(negedge clk); idle();
    rn_valid_mask = 3'b001; rn_src1_areg[0] = 5'd5;
    #1;
    tests++;
    if (rn_src1_preg[0] !== 6'd32 || rn_src1_ready[0] !== 1'b0) begin
      fails++; $display("FAIL basic_next_lookup: preg=%0d rdy=%b want 32 0", rn_src1_preg[0], rn_src1_ready[0]);
    end
  endtask

  task automatic test_intra_bypass();
    @(negedge clk); idle();
    rn_valid_mask = 3'b111; fl_alloc_valid_mask = 3'b111;
    rn_dest_areg[0] = 5'd4; fl_allocated_pr_list[0] = 6'd40;
    rn_src1_areg[1] = 5'd4; rn_dest_areg[1] = 5'd4; fl_allocated_pr_list[1] = 6'd41;
    rn_src2_areg[2] = 5'd4;
    #1;
    tests++;
    if (rn_src1_preg[1] !== 6'd40 || rn_src1_ready[1] !== 1'b0 || rn_told_preg[1] !== 6'd40) begin
      fails++; $display("FAIL bypass_slot1: src=%0d rdy=%b told=%0d want 40 0 40", rn_src1_preg[1], rn_src1_ready[1], rn_told_preg[1]);
    end
    tests++;
    if (rn_src2_preg[2] !== 6'd41 || rn_src2_ready[2] !== 1'b0 || rn_told_preg[0] !== 6'd4) begin
      fails++; $display("FAIL bypass_slot2: src2=%0d rdy=%b told0=%0d want 41 0 4", rn_src2_preg[2], rn_src2_ready[2], rn_told_preg[0]);
    end
    @(negedge clk); idle();
    rn_valid_mask = 3'b001; rn_src1_areg[0] = 5'd4;
    #1;
    tests++;
    if (rn_src1_preg[0] !== 6'd41) begin
      fails++; $display("FAIL bypass_youngest_wins: got %0d want 41", rn_src1_preg[0]);
    end
  endtask

  task automatic test_alloc_block();
    @(negedge clk); idle();
    rn_valid_mask = 3'b111; fl_alloc_valid_mask = 3'b101;
    rn_dest_areg[0] = 5'd8; rn_dest_areg[1] = 5'd9; rn_dest_areg[2] = 5'd10;
    fl_allocated_pr_list[0] = 6'd42; fl_allocated_pr_list[1] = 6'd43; fl_allocated_pr_list[2] = 6'd44;
    #1;
    tests++;
    if (rn_accept_mask !== 3'b001 || fl_dispatch_en_mask !== 3'b001 || rn_dest_preg !== {6'd0, 6'd0, 6'd42}) begin
      fails++; $display("FAIL block_prefix: acc=%b disp=%b dest=%h", rn_accept_mask, fl_dispatch_en_mask, rn_dest_preg);
    end
    @(negedge clk);
    rn_dest_areg[1] = 5'd0;
    fl_allocated_pr_list[0] = 6'd45; fl_allocated_pr_list[1] = 6'd46; fl_allocated_pr_list[2] = 6'd47;
    #1;
    tests++;
    if (rn_accept_mask !== 3'b111 || fl_dispatch_en_mask !== 3'b101 || rn_dest_preg !== {6'd47, 6'd0, 6'd45}) begin
      fails++; $display("FAIL block_dest0: acc=%b disp=%b dest=%h", rn_accept_mask, fl_dispatch_en_mask, rn_dest_preg);
    end
    tests++;
    if (rn_told_preg[0] !== 6'd42 || rn_told_preg[2] !== 6'd10) begin
      fails++; $display("FAIL block_told: t0=%0d t2=%0d want 42 10", rn_told_preg[0], rn_told_preg[2]);
    end
  endtask

  task automatic test_cdb();
    @(negedge clk); idle();
    rn_valid_mask = 3'b001; rn_src1_areg[0] = 5'd5;
    #1;
    tests++;
    if (rn_src1_ready[0] !== 1'b0) begin
      fails++; $display("FAIL cdb_pre: rdy=%b want 0", rn_src1_ready[0]);
    end
    cdb_valid = 3'b001; cdb_tag[0] = 6'd32;
    #1;
    tests++;
    if (rn_src1_preg[0] !== 6'd32 || rn_src1_ready[0] !== 1'b1) begin
      fails++; $display("FAIL cdb_same_cycle: preg=%0d rdy=%b want 32 1", rn_src1_preg[0], rn_src1_ready[0]);
    end
    @(negedge clk); idle();
    rn_valid_mask = 3'b001; rn_src1_areg[0] = 5'd5;
    #1;
    tests++;
    if (rn_src1_ready[0] !== 1'b1) begin
      fails++; $display("FAIL cdb_sticky: rdy=%b want 1", rn_src1_ready[0]);
    end
  endtask

  task automatic test_recovery();
    @(negedge clk); idle();
    rn_valid_mask = 3'b111; fl_alloc_valid_mask = 3'b111; fch_rec_enable = 1'b1;
    rn_dest_areg[0] = 5'd11; rn_dest_areg[1] = 5'd12; rn_dest_areg[2] = 5'd13;
    fl_allocated_pr_list[0] = 6'd50; fl_allocated_pr_list[1] = 6'd51; fl_allocated_pr_list[2] = 6'd52;
    #1;
    tests++;
    if (rn_accept_mask !== 3'b000 || fl_dispatch_en_mask !== 3'b000) begin
      fails++; $display("FAIL rec_blocks: acc=%b disp=%b want 000 000", rn_accept_mask, fl_dispatch_en_mask);
    end
    @(negedge clk); idle();
    rn_valid_mask = 3'b011;
    rn_src1_areg[0] = 5'd5; rn_src2_areg[0] = 5'd8; rn_src1_areg[1] = 5'd11; rn_src2_areg[1] = 5'd4;
    #1;
    tests++;
    if (rn_src1_preg !== {6'd0, 6'd11, 6'd5} || rn_src2_preg !== {6'd0, 6'd4, 6'd8} ||
        rn_src1_ready !== 3'b011 || rn_src2_ready !== 3'b011) begin
      fails++; $display("FAIL rec_restored: s1=%h s2=%h r1=%b r2=%b", rn_src1_preg, rn_src2_preg, rn_src1_ready, rn_src2_ready);
    end
    @(negedge clk); idle();
    rn_valid_mask = 3'b001; fl_alloc_valid_mask = 3'b001;
    rn_dest_areg[0] = 5'd6; fl_allocated_pr_list[0] = 6'd50;
    @(negedge clk); idle();
    rn_valid_mask = 3'b001; rn_src1_areg[0] = 5'd6;
    #1;
    tests++;
    if (rn_src1_preg[0] !== 6'd50) begin
      fails++; $display("FAIL rec_rename_after: got %0d want 50", rn_src1_preg[0]);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (rn_src1_preg[0] !== 6'd6 || rn_src1_ready[0] !== 1'b1) begin
      fails++; $display("FAIL midop_reset: preg=%0d rdy=%b want 6 1", rn_src1_preg[0], rn_src1_ready[0]);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    int n_bad;
    @(negedge clk); idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); idle();
      for (int i = 0; i < WIDTH; i++) begin
        rn_valid_mask[i]        = ($urandom_range(0, 3) != 0);
        rn_dest_areg[i]         = 5'($urandom_range(0, 7));
        rn_src1_areg[i]         = 5'($urandom_range(0, 7));
        rn_src2_areg[i]         = 5'($urandom_range(0, 9));
        fl_allocated_pr_list[i] = 6'($urandom_range(1, 63));
        fl_alloc_valid_mask[i]  = ($urandom_range(0, 4) != 0);
      end
      for (int k = 0; k < CDB_WIDTH; k++) begin
        cdb_valid[k] = ($urandom_range(0, 1) != 0);
        cdb_tag[k]   = 6'($urandom_range(0, 63));
      end
      fch_rec_enable = ($urandom_range(0, 15) == 0);
      if (fch_rec_enable)
        for (int a = 0; a < ARCH_REGS; a++) arch_map_in[a] = 6'($urandom_range(0, 63));
      model_eval();
      #1;
      for (int i = 0; i < WIDTH; i++) begin
        tests++;
        n_bad = 0;
        if (rn_accept_mask[i] !== e_acc[i] || fl_dispatch_en_mask[i] !== e_disp[i]) n_bad++;
        if (int'(rn_dest_preg[i]) != e_dest[i] || int'(rn_told_preg[i]) != e_told[i]) n_bad++;
        if (int'(rn_src1_preg[i]) != e_s1[i] || rn_src1_ready[i] !== e_r1[i]) n_bad++;
        if (int'(rn_src2_preg[i]) != e_s2[i] || rn_src2_ready[i] !== e_r2[i]) n_bad++;
        if (n_bad != 0) begin
          fails++;
          $display("FAIL random_c%0d_slot%0d: got acc=%b disp=%b dest=%0d told=%0d s1=%0d/%b s2=%0d/%b want acc=%b disp=%b dest=%0d told=%0d s1=%0d/%b s2=%0d/%b",
                   c, i, rn_accept_mask[i], fl_dispatch_en_mask[i], rn_dest_preg[i], rn_told_preg[i],
                   rn_src1_preg[i], rn_src1_ready[i], rn_src2_preg[i], rn_src2_ready[i],
                   e_acc[i], e_disp[i], e_dest[i], e_told[i], e_s1[i], e_r1[i], e_s2[i], e_r2[i]);
        end
      end
      model_commit();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_rename();
    test_intra_bypass();
    test_alloc_block();
    test_cdb();
    test_recovery();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
